// File: rtl/wave_gen.sv
// Direct-digital-synthesis waveform generator: prescaled phase accumulator,
// shadowed controls, and a 3-edge sample pipeline with an external sine ROM.
module wave_gen #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned ROM_AW  = 10,
    parameter int unsigned PRE_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                sync,
    input  logic [2:0]          mode,
    input  logic [PHASE_W-1:0]  step,
    input  logic [PHASE_W-1:0]  phase_off,
    input  logic [DATA_W:0]     amplitude,
    input  logic [PRE_W-1:0]    prescaler,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [DATA_W-1:0]   data,
    output logic                valid,
    output logic                wrap
);

    localparam logic [2:0] MODE_SIN = 3'd0;
    localparam logic [2:0] MODE_COS = 3'd1;
    localparam logic [2:0] MODE_SQR = 3'd2;
    localparam logic [2:0] MODE_SAW = 3'd3;
    localparam logic [2:0] MODE_TRI = 3'd4;

    localparam int unsigned PROD_W = 2 * DATA_W + 1;
    localparam logic [PHASE_W-1:0] QUARTER  = PHASE_W'(1) << (PHASE_W - 2);
    localparam logic [DATA_W-1:0]  MIDSCALE = DATA_W'(1) << (DATA_W - 1);
    localparam logic [DATA_W:0]    UNITY    = (DATA_W + 1)'(1) << DATA_W;

    logic [PRE_W-1:0]   cnt;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] step_s;
    logic [PHASE_W-1:0] off_s;
    logic [2:0]         mode_s;
    logic [DATA_W:0]    amp_s;

    // stage 0: snapshot of the phase being sampled by this tick
    logic [PHASE_W-1:0] ph0;
    logic [2:0]         mode0;
    logic [DATA_W:0]    amp0;
    logic               t0;
    // stage 1: ROM address issued
    logic [PHASE_W-1:0] p1;
    logic [2:0]         mode1;
    logic [DATA_W:0]    amp1;
    logic               t1;
    // stage 2: raw sample
    logic [DATA_W-1:0]  r;
    logic [DATA_W:0]    amp2;
    logic               t2;

    logic               tick_c;
    logic               shadow_ld_c;
    logic [PHASE_W:0]   sum_c;
    logic [PHASE_W-1:0] rom_ph_c;
    logic [DATA_W-1:0]  tri_c;
    logic [DATA_W-1:0]  raw_c;
    logic [DATA_W:0]    amp_eff_c;
    logic [DATA_W-1:0]  scaled_c;

    assign tick_c      = ena && (cnt >= prescaler) && !sync;
    assign shadow_ld_c = !ena || wrap || sync;
    assign sum_c       = {1'b0, acc} + {1'b0, step_s};

    // Prescaler and phase accumulator; sync wins over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            acc  <= '0;
            wrap <= 1'b0;
        end else if (sync) begin
            cnt  <= '0;
            acc  <= '0;
            wrap <= 1'b0;
        end else if (tick_c) begin
            cnt  <= '0;
            acc  <= sum_c[PHASE_W-1:0];
            wrap <= sum_c[PHASE_W];
        end else begin
            cnt  <= ena ? cnt + PRE_W'(1) : '0;
            wrap <= 1'b0;
        end
    end

    // Control shadows only move while idle or at a period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s <= '0;
            step_s <= '0;
            off_s  <= '0;
            amp_s  <= '0;
        end else if (shadow_ld_c) begin
            mode_s <= mode;
            step_s <= step;
            off_s  <= phase_off;
            amp_s  <= amplitude;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph0   <= '0;
            mode0 <= '0;
            amp0  <= '0;
            t0    <= 1'b0;
        end else begin
            t0 <= tick_c;
            if (tick_c) begin
                ph0   <= acc + off_s;
                mode0 <= mode_s;
                amp0  <= amp_s;
            end
        end
    end

    assign rom_ph_c = (mode0 == MODE_COS) ? ph0 + QUARTER : ph0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            p1       <= '0;
            mode1    <= '0;
            amp1     <= '0;
            t1       <= 1'b0;
        end else begin
            rom_addr <= ROM_AW'(rom_ph_c >> (PHASE_W - ROM_AW));
            p1       <= ph0;
            mode1    <= mode0;
            amp1     <= amp0;
            t1       <= t0;
        end
    end

    assign tri_c = DATA_W'(p1 >> (PHASE_W - 1 - DATA_W));

    // Raw waveform selection; ROM data arrives alongside this stage.
    always_comb begin
        raw_c = MIDSCALE;
        case (mode1)
            MODE_SIN, MODE_COS: raw_c = rom_data;
            MODE_SQR:           raw_c = p1[PHASE_W-1] ? '0 : '1;
            MODE_SAW:           raw_c = DATA_W'(p1 >> (PHASE_W - DATA_W));
            MODE_TRI:           raw_c = p1[PHASE_W-1] ? ~tri_c : tri_c;
            default:            raw_c = MIDSCALE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r    <= '0;
            amp2 <= '0;
            t2   <= 1'b0;
        end else begin
            r    <= raw_c;
            amp2 <= amp1;
            t2   <= t1;
        end
    end

    assign amp_eff_c = (amp2 > UNITY) ? UNITY : amp2;
    assign scaled_c  = DATA_W'((PROD_W'(r) * PROD_W'(amp_eff_c)) >> DATA_W);

    // Output stage: data only moves with a strobed sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= t2;
            if (t2) begin
                data <= scaled_c;
            end
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Directed bench for wave_gen: sawtooth/square/cos/sine/triangle sequences,
// prescaling, amplitude clamp, reset and sync behaviour.
module tb_wave_gen;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PHASE_W = 24;
    localparam int unsigned ROM_AW  = 10;
    localparam int unsigned PRE_W   = 16;

    logic                clk;
    logic                rst_n;
    logic                ena;
    logic                sync;
    logic [2:0]          mode;
    logic [PHASE_W-1:0]  phase_step;
    logic [PHASE_W-1:0]  phase_off;
    logic [DATA_W:0]     amplitude;
    logic [PRE_W-1:0]    prescaler;
    logic [ROM_AW-1:0]   rom_addr;
    logic [DATA_W-1:0]   rom_data;
    logic [DATA_W-1:0]   data;
    logic                valid;
    logic                wrap;

    int n_run  = 0;
    int n_fail = 0;

    int bad, early, nwrap, w1, w2, nv, first_v, last_v, badsp, hold_bad;
    logic [15:0] expd;
    logic [15:0] last_d;
    logic        vv [1:7];
    logic [15:0] dd [1:7];
    logic [15:0] got [$];

    wave_gen #(
        .DATA_W (DATA_W),
        .PHASE_W(PHASE_W),
        .ROM_AW (ROM_AW),
        .PRE_W  (PRE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .sync     (sync),
        .mode     (mode),
        .step     (phase_step),
        .phase_off(phase_off),
        .amplitude(amplitude),
        .prescaler(prescaler),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .data     (data),
        .valid    (valid),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: an arbitrary but distinct value per address.
    function automatic logic [15:0] rom_f(input logic [9:0] a);
        rom_f = 16'(a) * 16'd61 + 16'h1234;
    endfunction

    assign rom_data = rom_f(rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic collect(input int n);
        got.delete();
        repeat (n) begin
            cyc();
            if (valid) got.push_back(data);
        end
    endtask

    task automatic prep(input logic [2:0] m, input logic [23:0] st, input logic [23:0] of,
                        input logic [16:0] am, input logic [15:0] pr);
        ena        = 1'b0;
        sync       = 1'b0;
        mode       = m;
        phase_step = st;
        phase_off  = of;
        amplitude  = am;
        prescaler  = pr;
        repeat (5) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b0;
        sync       = 1'b0;
        mode       = 3'd3;
        phase_step = 24'h010000;
        phase_off  = '0;
        amplitude  = 17'h10000;
        prescaler  = '0;

        // reset state
        repeat (2) cyc();
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_addr", 32'(rom_addr), 32'h0);
        rst_n = 1'b1;
        repeat (3) cyc();

        // sawtooth, prescaler 0: latency, ramp, wrap every 256 ticks
        ena = 1'b1;
        bad = 0; early = 0; nwrap = 0; w1 = -1; w2 = -1; first_v = -1;
        for (int i = 1; i <= 560; i++) begin
            cyc();
            if (wrap) begin
                nwrap++;
                if (w1 < 0) w1 = i;
                else if (w2 < 0) w2 = i;
            end
            if (valid && first_v < 0) first_v = i;
            if (i <= 3) begin
                if (valid) early++;
            end else begin
                expd = 16'((i - 4) * 256);
                if (!valid || data !== expd) bad++;
            end
        end
        check("saw_early_valid", 32'(early), 32'd0);
        check("saw_first_valid", 32'(first_v), 32'd4);
        check("saw_seq", 32'(bad), 32'd0);
        check("saw_nwrap", 32'(nwrap), 32'd2);
        check("saw_wrap1", 32'(w1), 32'd256);
        check("saw_wrap2", 32'(w2), 32'd512);

        // prescaler 3: one valid every four cycles, data holds between
        prep(3'd3, 24'h010000, 24'h0, 17'h10000, 16'd3);
        ena = 1'b1;
        nv = 0; first_v = -1; last_v = -1; badsp = 0; bad = 0; hold_bad = 0;
        expd = 16'h0000;
        last_d = data;
        for (int i = 1; i <= 64; i++) begin
            cyc();
            if (valid) begin
                nv++;
                if (first_v < 0) first_v = i;
                else if (i - last_v != 4) badsp++;
                if (data !== expd) bad++;
                expd = expd + 16'h0100;
                last_v = i;
                last_d = data;
            end else if (data !== last_d) begin
                hold_bad++;
            end
        end
        check("pre_count", 32'(nv), 32'd15);
        check("pre_first", 32'(first_v), 32'd7);
        check("pre_spacing", 32'(badsp), 32'd0);
        check("pre_data", 32'(bad), 32'd0);
        check("pre_hold", 32'(hold_bad), 32'd0);

        // square at half amplitude
        prep(3'd2, 24'h400000, 24'h0, 17'h08000, 16'd0);
        ena = 1'b1;
        collect(12);
        check("sq_half_cnt", 32'(got.size()), 32'd9);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            expd = ((k % 4) < 2) ? 16'h7FFF : 16'h0000;
            if (k >= got.size() || got[k] !== expd) bad++;
        end
        check("sq_half_seq", 32'(bad), 32'd0);

        // square with over-unity amplitude clamps to unity
        prep(3'd2, 24'h400000, 24'h0, 17'h1FFFF, 16'd0);
        ena = 1'b1;
        collect(12);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            expd = ((k % 4) < 2) ? 16'hFFFF : 16'h0000;
            if (k >= got.size() || got[k] !== expd) bad++;
        end
        check("sq_clamp_seq", 32'(bad), 32'd0);

        // cosine at phase 0 reads the quarter-wave address
        prep(3'd1, 24'h0, 24'h0, 17'h10000, 16'd0);
        ena = 1'b1;
        repeat (2) cyc();
        check("cos_addr", 32'(rom_addr), 32'd256);
        repeat (2) cyc();
        check("cos_valid", 32'(valid), 32'd1);
        check("cos_data", 32'(data), 32'(rom_f(10'd256)));

        // sine at phase 0, then with an eighth-turn offset
        prep(3'd0, 24'h0, 24'h0, 17'h10000, 16'd0);
        ena = 1'b1;
        repeat (2) cyc();
        check("sin_addr", 32'(rom_addr), 32'd0);
        repeat (2) cyc();
        check("sin_data", 32'(data), 32'(rom_f(10'd0)));
        prep(3'd0, 24'h0, 24'h200000, 17'h10000, 16'd0);
        ena = 1'b1;
        repeat (2) cyc();
        check("sin_off_addr", 32'(rom_addr), 32'd128);
        repeat (2) cyc();
        check("sin_off_data", 32'(data), 32'(rom_f(10'd128)));

        // saw -> triangle switch mid-period takes effect after the wrap
        prep(3'd3, 24'h100000, 24'h0, 17'h10000, 16'd1);
        ena = 1'b1;
        got.delete();
        for (int i = 1; i <= 70; i++) begin
            if (i == 6) mode = 3'd4;
            cyc();
            if (valid) got.push_back(data);
        end
        check("switch_cnt", 32'(got.size()), 32'd33);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (k < 16) expd = 16'(k * 16'h1000);
            else if (k - 16 < 8) expd = 16'((k - 16) * 16'h2000);
            else expd = 16'hFFFF - 16'((k - 24) * 16'h2000);
            if (k >= got.size() || got[k] !== expd) bad++;
        end
        check("switch_seq", 32'(bad), 32'd0);

        // triangle peak
        prep(3'd4, 24'h0, 24'h7FFFFF, 17'h10000, 16'd0);
        ena = 1'b1;
        repeat (4) cyc();
        check("tri_peak_valid", 32'(valid), 32'd1);
        check("tri_peak", 32'(data), 32'hFFFF);

        // one-cycle reset mid-stream
        prep(3'd3, 24'h010000, 24'h0, 17'h10000, 16'd0);
        ena = 1'b1;
        repeat (10) cyc();
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_addr", 32'(rom_addr), 32'h0);
        check("mid_rst_wrap", 32'(wrap), 32'h0);
        cyc();
        rst_n = 1'b1;
        early = 0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (i <= 3 && valid) early++;
            if (i == 4) begin
                check("post_rst_valid", 32'(valid), 32'd1);
                check("post_rst_data", 32'(data), 32'h0);
            end
        end
        check("post_rst_stray", 32'(early), 32'd0);
        repeat (8) cyc();

        // sync pulse coinciding with a tick
        sync = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            sync = 1'b0;
            vv[i] = valid;
            dd[i] = data;
        end
        check("sync_inflight", 32'({vv[1], vv[2], vv[3]}), 32'b111);
        check("sync_gap", 32'(vv[4]), 32'd0);
        check("sync_s0", 32'({vv[5], dd[5]}), 32'h10000);
        check("sync_s1", 32'({vv[6], dd[6]}), 32'h10100);
        check("sync_s2", 32'({vv[7], dd[7]}), 32'h10200);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_gen.md
# wave_gen

Parametrised direct-digital-synthesis waveform generator; successor to the single-mode cosine generator. Phase accumulator with prescaled tick, runtime-selectable waveform (sine, cosine, square, sawtooth, triangle), phase offset and amplitude scaling. Sine/cosine samples come from an external full-wave ROM with 1-cycle read latency. Output is an unsigned offset-binary sample stream with a per-sample valid strobe, feeding the DAC/output stage.

## Interface
- DATA_W, 16, sample width.
- PHASE_W, 24, phase accumulator width; must be ≥ DATA_W+1.
- ROM_AW, 10, ROM address width; must be ≤ PHASE_W.
- PRE_W, 16, prescaler width.

- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  run enable.
- sync  in  1  synchronous accumulator clear, single-cycle pulse.
- mode  in  3  0 sine, 1 cosine, 2 square, 3 sawtooth, 4 triangle, 5-7 midscale.
- step  in  PHASE_W  phase increment per tick.
- phase_off  in  PHASE_W  phase offset.
- amplitude  in  DATA_W+1  gain; 2^DATA_W = unity; larger values clamp to unity.
- prescaler  in  PRE_W  tick every prescaler+1 cycles.
- rom_addr  out  ROM_AW  registered ROM address.
- rom_data  in  DATA_W  ROM output, valid 1 cycle after rom_addr.
- data  out  DATA_W  scaled sample.
- valid  out  1  one-cycle strobe per new sample.
- wrap  out  1  one-cycle pulse when the accumulator carries out.

## Operation
- Prescale counter: counts 0..prescaler. A tick occurs in cycles where counter == prescaler and ena=1; counter returns to 0 on the tick. ena=0 holds counter at 0.
- On a tick: acc <= acc + step_s (mod 2^PHASE_W). wrap pulses in the same cycle as the updated acc when the add carries out.
- sync=1: acc <= 0 and counter <= 0, with priority over a tick in the same cycle. Shadows reload.
- Shadow registers mode_s, step_s, off_s, amp_s:
  - load from inputs every cycle while ena=0;
  - while ena=1, load only in the cycle of a wrap or sync.
  - Changing inputs mid-period is therefore glitch-free.
- Effective phase p = acc + off_s; cosine uses p + 2^(PHASE_W-2).
- rom_addr = top ROM_AW bits of the effective phase.
- Raw sample r (DATA_W bits):
  - sine/cosine: rom_data;
  - square: p MSB 0 → all ones, 1 → 0;
  - saw: p[PHASE_W-1 -: DATA_W];
  - triangle: t = p[PHASE_W-2 -: DATA_W], r = MSB ? ~t : t;
  - modes 5-7: 2^(DATA_W-1).
- Scaling: data = (r × min(amp_s, 2^DATA_W)) >> DATA_W. Unity returns r exactly.
- ena=0: no new ticks; samples already in flight complete and strobe valid; data then holds.

## Timing
- Pipeline, measured from the edge that updates acc (E0):
  - E1 registers rom_addr and captures mode/p;
  - E2 registers r, sampling rom_data;
  - E3 registers data and asserts valid.
- Latency is 3 edges; throughput is one sample per tick.
- prescaler=0 → valid continuously high while running.
- Reset (async assert, sync-safe deassert):
  - acc=0, counter=0, rom_addr=0;
  - shadows=0, except amp_s=0;
  - data=0, valid=0, wrap=0;
  - pipeline cleared, no valid pulses from pre-reset samples.
- Reset mid-stream drops in-flight samples. First valid after release comes 3 edges after the first tick.
- A tick and a wrap in the same cycle as a shadow reload: the new step applies to the next tick, not the current one.

## Test plan
- Sawtooth, unity amp, step=2^16, prescaler=0, ena=1 after reset → data 0x0000, 0x0100, 0x0200…, valid held high; wrap every 256 ticks; first valid 3 edges after the first acc update.
- prescaler=3, sawtooth step=2^16 → valid exactly one cycle in four; data steps by 0x0100 per valid; no other data changes.
- Square, amplitude=0x08000, step=2^22 → data alternates 0x7FFF ×2, 0x0000 ×2; amplitude=0x1FFFF → 0xFFFF/0x0000 (clamped).
- Cosine, phase_off=0, acc=0, ROM_AW=10, ROM model with 1-cycle latency → rom_addr=256; data equals ROM[256]; sine mode gives rom_addr=0.
- Switch mode saw→triangle mid-period with step=2^20 → saw continues until the wrap pulse; triangle samples start with the first tick after wrap; triangle peaks at 0xFFFF at p=0x7FFFFF.
- Assert rst_n=0 for one cycle mid-stream, then sync pulse test → all outputs 0 immediately; no stray valid; sync during a tick leaves acc=0.
